// File: rtl/nmca_pkg.sv
// Shared definitions for the requantization datapath: default widths and a
// signed saturation helper used by acc_requant.
package nmca_pkg;

  localparam int ACC_WIDTH   = 40;
  localparam int OUT_WIDTH   = 16;
  localparam int BIAS_WIDTH  = 32;
  localparam int SCALE_WIDTH = 16;
  localparam int SHIFT_WIDTH = 6;

  // Clamp a signed value into the range of a signed field 'width' bits wide.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                    input int unsigned width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/acc_requant_pipe_stage.sv
// One pipeline slot: valid bit plus payload, captured when load_i is high.
// The payload only changes for real beats, so it holds its last value across
// bubbles and while stalled.
module pipe_stage
  import nmca_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load_i,
  input  logic         vld_i,
  input  logic [W-1:0] data_i,
  output logic         vld_o,
  output logic [W-1:0] data_o
);

  logic         vld_q;
  logic [W-1:0] data_q;

  // Take the upstream slot (beat or bubble) whenever this stage is allowed to load.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else if (load_i) begin
      vld_q <= vld_i;
      if (vld_i) data_q <= data_i;
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;

endmodule

// File: rtl/acc_requant.sv
// acc_requant: bias add, unsigned scale multiply, rounding arithmetic right
// shift and saturation of PE-array accumulator results, as a 3-stage
// valid/ready pipeline with bubble collapsing and a saturation event counter.
// Optional build macro: ACC_REQUANT_RELU_EN clamps negative results to zero
// ahead of saturation (the ReLU clamp never counts as a saturation event).
module acc_requant
  import nmca_pkg::*;
#(
  parameter int ACC_WIDTH   = nmca_pkg::ACC_WIDTH,
  parameter int OUT_WIDTH   = nmca_pkg::OUT_WIDTH,
  parameter int BIAS_WIDTH  = nmca_pkg::BIAS_WIDTH,
  parameter int SCALE_WIDTH = nmca_pkg::SCALE_WIDTH,
  parameter int SHIFT_WIDTH = nmca_pkg::SHIFT_WIDTH,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [ACC_WIDTH-1:0]   in_acc,
  input  logic signed [BIAS_WIDTH-1:0]  bias,
  input  logic        [SCALE_WIDTH-1:0] scale,
  input  logic        [SHIFT_WIDTH-1:0] shift,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [OUT_WIDTH-1:0]   out_data,
  input  logic                          clear_stats,
  output logic        [CNT_WIDTH-1:0]   sat_count
);

  localparam int SUM_W  = ACC_WIDTH + 1;
  localparam int PROD_W = ACC_WIDTH + SCALE_WIDTH + 2;
  localparam int SMAX   = ACC_WIDTH + SCALE_WIDTH;
  localparam int P1_W   = SUM_W + SCALE_WIDTH + SHIFT_WIDTH;
  localparam int P2_W   = PROD_W + SHIFT_WIDTH;
  localparam int P3_W   = OUT_WIDTH + 1;

  // Round half up toward +inf, then arithmetic shift; one guard bit absorbs the carry.
  function automatic logic signed [PROD_W:0] round_shift(input logic signed [PROD_W-1:0] v,
                                                         input logic [SHIFT_WIDTH-1:0] s);
    logic signed [PROD_W:0] ext;
    logic signed [PROD_W:0] half;
    ext  = {v[PROD_W-1], v};
    if (s == '0) return ext;
    half = '0;
    half[s - 1'b1] = 1'b1;
    return (ext + half) >>> s;
  endfunction

  logic vld_p1, vld_p2, vld_p3;
  logic load_p1, load_p2, load_p3;

  // A stage loads when empty or when its occupant moves on this cycle.
  assign load_p3  = !vld_p3 || out_ready;
  assign load_p2  = !vld_p2 || load_p3;
  assign load_p1  = !vld_p1 || load_p2;
  assign in_ready = load_p1;

  // ---- stage 1: exact bias add, scale and shift travel with the beat ----
  logic signed [SUM_W-1:0]       sum_d;
  logic        [P1_W-1:0]        pay_p1;
  logic signed [SUM_W-1:0]       sum_p1;
  logic        [SCALE_WIDTH-1:0] scale_p1;
  logic        [SHIFT_WIDTH-1:0] shift_p1;

  assign sum_d = {in_acc[ACC_WIDTH-1], in_acc}
               + {{(SUM_W-BIAS_WIDTH){bias[BIAS_WIDTH-1]}}, bias};

  pipe_stage #(.W(P1_W)) u_stage1 (
    .clk    (clk),
    .rstn   (rstn),
    .load_i (load_p1),
    .vld_i  (in_valid),
    .data_i ({sum_d, scale, shift}),
    .vld_o  (vld_p1),
    .data_o (pay_p1)
  );

  assign {sum_p1, scale_p1, shift_p1} = pay_p1;

  // ---- stage 2: exact product with zero-extended scale ----
  logic signed [PROD_W-1:0]      prod_d;
  logic        [P2_W-1:0]        pay_p2;
  logic signed [PROD_W-1:0]      prod_p2;
  logic        [SHIFT_WIDTH-1:0] shift_p2;

  assign prod_d = $signed({{(PROD_W-SUM_W){sum_p1[SUM_W-1]}}, sum_p1})
                * $signed({{(PROD_W-SCALE_WIDTH){1'b0}}, scale_p1});

  pipe_stage #(.W(P2_W)) u_stage2 (
    .clk    (clk),
    .rstn   (rstn),
    .load_i (load_p2),
    .vld_i  (vld_p1),
    .data_i ({prod_d, shift_p1}),
    .vld_o  (vld_p2),
    .data_o (pay_p2)
  );

  assign {prod_p2, shift_p2} = pay_p2;

  // ---- stage 3: shift clamp, rounding, optional ReLU, saturation ----
  logic        [SHIFT_WIDTH-1:0] shc;
  logic signed [PROD_W:0]        rnd;
  logic signed [63:0]            r64;
  logic signed [63:0]            sat64;
  logic                          sat_d;
  logic signed [OUT_WIDTH-1:0]   q_d;
  logic        [P3_W-1:0]        pay_p3;
  logic                          sat_p3;

  // Requantize the product held in stage 2.
  always_comb begin
    shc = shift_p2;
    if (int'(shift_p2) > SMAX) shc = SHIFT_WIDTH'(SMAX);
    rnd = round_shift(prod_p2, shc);
    r64 = {{(64-PROD_W-1){rnd[PROD_W]}}, rnd};
`ifdef ACC_REQUANT_RELU_EN
    if (r64 < 0) r64 = '0;
`endif
    sat64 = sat_signed(r64, OUT_WIDTH);
    sat_d = (sat64 != r64);
    q_d   = sat64[OUT_WIDTH-1:0];
  end

  pipe_stage #(.W(P3_W)) u_stage3 (
    .clk    (clk),
    .rstn   (rstn),
    .load_i (load_p3),
    .vld_i  (vld_p2),
    .data_i ({sat_d, q_d}),
    .vld_o  (vld_p3),
    .data_o (pay_p3)
  );

  assign sat_p3    = pay_p3[OUT_WIDTH];
  assign out_data  = pay_p3[OUT_WIDTH-1:0];
  assign out_valid = vld_p3;

  // ---- saturation statistics ----
  logic [CNT_WIDTH-1:0] sat_cnt_q, sat_cnt_d;

  // Count saturated results as they leave; stick at all-ones; clear has priority.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (clear_stats) sat_cnt_d = '0;
    else if (out_valid && out_ready && sat_p3 && (sat_cnt_q != '1))
      sat_cnt_d = sat_cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sat_cnt_q <= '0;
    else       sat_cnt_q <= sat_cnt_d;
  end

  assign sat_count = sat_cnt_q;

endmodule
